// File: rtl/stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// stopwatch_sequencer
//
// Control block between the four stopwatch pushbuttons and the counter /
// 7-segment datapath. Each active-low button is synchronised (2 FF) and
// debounced, then turned into a one-cycle press event. A RUN/PAUSE/DONE state
// machine consumes the events and a clock-enable prescaler paces counting in
// RUN. No derived clocks are produced.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_n[3:0] raw active-low buttons: [0] start, [1] stop, [2] step, [3] clear
//   cnt_val    current counter value fed back from the counter (unsigned)
//   cnt_en     one-cycle count-enable pulse to the counter
//   cnt_clr    one-cycle synchronous clear pulse to the counter
//   disp_hold  display freeze (lap) flag
//   led[3:0]   one-hot state: [0] IDLE, [1] RUN, [2] PAUSE, [3] DONE
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module stopwatch_sequencer #(
    parameter int N         = 16,
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000,
    parameter int MAX_COUNT = 9999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   btn_n,
    input  logic [N-1:0] cnt_val,
    output logic         cnt_en,
    output logic         cnt_clr,
    output logic         disp_hold,
    output logic [3:0]   led
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
    localparam logic [N-1:0]    MAX_VAL = N'(MAX_COUNT);

    // ------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press detector.
    // The press pulse is registered on the same edge that the debounced
    // level falls, so the state machine reacts one edge later.
    // ------------------------------------------------------------------
    logic [3:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            press_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg  <= 1'b1;
                    sync2_reg  <= 1'b1;
                    level_reg  <= 1'b1;
                    press_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_n[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        // Differed for DB_CYCLES consecutive cycles: accept it.
                        level_reg  <= sync2_reg;
                        db_cnt_reg <= '0;
                        press_reg  <= ~sync2_reg;   // only 1->0 is a press
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // Same-cycle events resolve as clear > stop > start > step; only the
    // winner is visible to the state machine.
    logic ev_clear, ev_stop, ev_start, ev_step;
    assign ev_clear = press[3];
    assign ev_stop  = press[1] & ~press[3];
    assign ev_start = press[0] & ~press[1] & ~press[3];
    assign ev_step  = press[2] & ~press[0] & ~press[1] & ~press[3];

    // ------------------------------------------------------------------
    // State machine and prescaler
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [TK_W-1:0] presc_reg, presc_next;
    logic            en_reg, en_next;
    logic            clr_reg, clr_next;
    logic            hold_reg, hold_next;
    logic [3:0]      led_reg, led_next;
    logic            below_max;
    logic            tick;

    assign below_max = (cnt_val < MAX_VAL);
    assign tick      = (state_reg == S_RUN) && (presc_reg == TK_LAST) && below_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            presc_reg <= '0;
            en_reg    <= 1'b0;
            clr_reg   <= 1'b0;
            hold_reg  <= 1'b0;
            led_reg   <= 4'b0001;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            en_reg    <= en_next;
            clr_reg   <= clr_next;
            hold_reg  <= hold_next;
            led_reg   <= led_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        en_next    = 1'b0;
        clr_next   = 1'b0;
        presc_next = '0;
        led_next   = 4'b0001;

        if (ev_clear) begin
            // Clear overrides everything, including a tick due this cycle.
            state_next = S_IDLE;
            clr_next   = 1'b1;
            hold_next  = 1'b0;
        end else begin
            en_next = tick;
            case (state_reg)
                S_IDLE, S_PAUSE: begin
                    if (ev_start) begin
                        state_next = S_RUN;
                    end else if (ev_step && below_max) begin
                        en_next = 1'b1;
                    end
                end
                S_RUN: begin
                    // Reaching the terminal count takes precedence over stop.
                    if (!below_max) begin
                        state_next = S_DONE;
                        hold_next  = 1'b0;
                    end else if (ev_stop) begin
                        state_next = S_PAUSE;
                        hold_next  = 1'b0;
                    end else if (ev_start) begin
                        hold_next = ~hold_reg;
                    end
                end
                default: begin
                    // DONE waits for clear.
                end
            endcase
        end

        // Prescaler only runs while staying in RUN, so every entry into RUN
        // starts a fresh full tick period.
        if ((state_reg == S_RUN) && (state_next == S_RUN)) begin
            presc_next = (presc_reg == TK_LAST) ? '0 : presc_reg + 1'b1;
        end

        case (state_next)
            S_IDLE:  led_next = 4'b0001;
            S_RUN:   led_next = 4'b0010;
            S_PAUSE: led_next = 4'b0100;
            default: led_next = 4'b1000;
        endcase
    end

    assign cnt_en    = en_reg;
    assign cnt_clr   = clr_reg;
    assign disp_hold = hold_reg;
    assign led       = led_reg;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_sequencer
//
// Bench for stopwatch_sequencer with TICK_DIV=10, DB_CYCLES=4, MAX_COUNT=20.
// A counter model driven by cnt_en/cnt_clr supplies cnt_val. A behavioural
// reference model predicts every output each cycle; a table of button
// presses with hand-derived expectations and a handful of directed sequences
// cover the corner cases, followed by randomized press/bounce traffic.
// -----------------------------------------------------------------------------
module tb_stopwatch_sequencer;

    localparam int N         = 16;
    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int MAX_COUNT = 20;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic [3:0]   btn_n = 4'hF;
    logic [N-1:0] cnt_val;
    logic         cnt_en;
    logic         cnt_clr;
    logic         disp_hold;
    logic [3:0]   led;

    int checks     = 0;
    int errors     = 0;
    int en_pulses  = 0;
    int clr_pulses = 0;

    stopwatch_sequencer #(
        .N         (N),
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .cnt_val   (cnt_val),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .disp_hold (disp_hold),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Counter datapath the sequencer drives.
    always @(posedge clk or posedge rst) begin
        if (rst)          cnt_val <= '0;
        else if (cnt_clr) cnt_val <= '0;
        else if (cnt_en)  cnt_val <= cnt_val + 1'b1;
    end

    // ------------------------------------------------------------------
    // Reference model: mode, time spent in RUN, per-button run lengths of
    // disagreement between the 2-cycle-delayed sample and the accepted
    // level, pending press events, and an expected counter value.
    // ------------------------------------------------------------------
    logic [3:0] m_s1, m_s2, m_db, m_ev;
    int         m_run [4];
    int         m_mode, m_phase, m_cnt;
    logic       m_en, m_clr, m_hold;

    function automatic void model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF; m_ev = 4'h0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_mode = M_IDLE; m_phase = 0; m_cnt = 0;
        m_en = 1'b0; m_clr = 1'b0; m_hold = 1'b0;
    endfunction

    function automatic logic [3:0] model_led();
        return 4'(1 << m_mode);
    endfunction

    // Advance the model by one clock edge given the pins seen at that edge.
    function automatic void model_advance(input logic [3:0] raw);
        int         cnt_pre;
        int         n_mode;
        logic       n_en, n_clr, n_hold, tick;
        logic [3:0] new_ev;
        cnt_pre = m_cnt;
        n_mode  = m_mode;
        n_en    = 1'b0;
        n_clr   = 1'b0;
        n_hold  = m_hold;
        new_ev  = 4'h0;

        if (m_clr)     m_cnt = 0;
        else if (m_en) m_cnt = m_cnt + 1;

        tick = (m_mode == M_RUN) && ((m_phase % TICK_DIV) == TICK_DIV - 1) && (cnt_pre < MAX_COUNT);
        if (m_ev[3]) begin
            n_mode = M_IDLE; n_clr = 1'b1; n_hold = 1'b0;
        end else begin
            n_en = tick;
            if (m_mode == M_RUN && cnt_pre >= MAX_COUNT) begin
                n_mode = M_DONE; n_hold = 1'b0;
            end else if (m_ev[1]) begin
                if (m_mode == M_RUN) begin n_mode = M_PAUSE; n_hold = 1'b0; end
            end else if (m_ev[0]) begin
                if (m_mode == M_RUN) n_hold = !m_hold;
                else if (m_mode == M_IDLE || m_mode == M_PAUSE) n_mode = M_RUN;
            end else if (m_ev[2]) begin
                if ((m_mode == M_IDLE || m_mode == M_PAUSE) && cnt_pre < MAX_COUNT) n_en = 1'b1;
            end
        end
        m_phase = (m_mode == M_RUN && n_mode == M_RUN) ? m_phase + 1 : 0;

        for (int b = 0; b < 4; b++) begin
            if (m_s2[b] != m_db[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == DB_CYCLES) begin
                    m_db[b]   = m_s2[b];
                    m_run[b]  = 0;
                    new_ev[b] = !m_s2[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;

        m_ev   = new_ev;
        m_mode = n_mode;
        m_en   = n_en;
        m_clr  = n_clr;
        m_hold = n_hold;
    endfunction

    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model sees the pins, DUT clocks, outputs compared mid-cycle.
    task automatic step();
        model_advance(btn_n);
        @(posedge clk);
        @(negedge clk);
        if (cnt_en === 1'b1)  en_pulses++;
        if (cnt_clr === 1'b1) clr_pulses++;
        check("led",       32'(led),       32'(model_led()));
        check("cnt_en",    32'(cnt_en),    32'(m_en));
        check("cnt_clr",   32'(cnt_clr),   32'(m_clr));
        check("disp_hold", 32'(disp_hold), 32'(m_hold));
        check("cnt_val",   32'(cnt_val),   32'(m_cnt));
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        btn_n = ~mask;
        repeat (hold) step();
        btn_n = 4'hF;
        repeat (gap) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " led"},       32'(led),       32'd1);
        check({tag, " cnt_en"},    32'(cnt_en),    32'd0);
        check({tag, " cnt_clr"},   32'(cnt_clr),   32'd0);
        check({tag, " disp_hold"}, 32'(disp_hold), 32'd0);
        check({tag, " cnt_val"},   32'(cnt_val),   32'd0);
    endtask

    // Called right after a negedge; asserts reset between clock edges.
    task automatic async_reset_mid_cycle();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0] mask;
        int         hold;
        int         gap;
        logic [3:0] exp_led;
        logic       exp_hold;
        int         exp_en;    // cnt_en pulses during the vector, -1 = don't care
        int         exp_clr;   // cnt_clr pulses during the vector, -1 = don't care
        int         exp_cnt;   // cnt_val afterwards, -1 = don't care
    } vec_t;

    vec_t vecs [14];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        logic [3:0] mask;
        int         hold, gap;

        // Starts in RUN (after the directed start-up sequence), lap off.
        vecs[0]  = '{4'b0001, 8, 10, 4'b0010, 1'b1, -1, 0, -1}; // start in RUN: lap on
        vecs[1]  = '{4'b0001, 8, 10, 4'b0010, 1'b0, -1, 0, -1}; // lap off
        vecs[2]  = '{4'b0001, 8, 10, 4'b0010, 1'b1, -1, 0, -1}; // lap on
        vecs[3]  = '{4'b0010, 8, 10, 4'b0100, 1'b0, -1, 0, -1}; // stop -> PAUSE
        vecs[4]  = '{4'b0010, 8, 50, 4'b0100, 1'b0,  0, 0, -1}; // stop in PAUSE, idle 50+
        vecs[5]  = '{4'b0100, 8, 10, 4'b0100, 1'b0,  1, 0, -1}; // step
        vecs[6]  = '{4'b0100, 8, 10, 4'b0100, 1'b0,  1, 0, -1}; // step
        vecs[7]  = '{4'b0100, 8, 10, 4'b0100, 1'b0,  1, 0, -1}; // step
        vecs[8]  = '{4'b0001, 8, 10, 4'b0010, 1'b0, -1, 0, -1}; // resume RUN
        vecs[9]  = '{4'b1001, 8, 10, 4'b0001, 1'b0, -1, 1,  0}; // start+clear: clear wins
        vecs[10] = '{4'b0010, 8, 10, 4'b0001, 1'b0,  0, 0,  0}; // stop in IDLE
        vecs[11] = '{4'b0011, 8, 10, 4'b0001, 1'b0,  0, 0,  0}; // stop outranks start
        vecs[12] = '{4'b0001, 8, 10, 4'b0010, 1'b0, -1, 0, -1}; // start -> RUN
        vecs[13] = '{4'b0100, 8, 10, 4'b0010, 1'b0, -1, 0, -1}; // step ignored in RUN

        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Start press latency: state changes DB_CYCLES+3 edges after first sample.
        btn_n[0] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            if (led == 4'b0010) lat = k;
        end
        check("start latency", 32'(lat), 32'(DB_CYCLES + 3));
        $display("start held: RUN after %0d edges", lat);

        // Tick spacing in RUN.
        for (int t = 0; t < 3; t++) begin
            lat = 0;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                step();
                if (cnt_en === 1'b1) lat = k;
            end
            check($sformatf("tick%0d spacing", t), 32'(lat), 32'(TICK_DIV));
        end
        step();
        check("cnt after 3 ticks", 32'(cnt_val), 32'd3);
        btn_n = 4'hF;
        repeat (DB_CYCLES + 4) step();

        // Table of button presses.
        for (int i = 0; i < 14; i++) begin
            en_pulses  = 0;
            clr_pulses = 0;
            press(vecs[i].mask, vecs[i].hold, vecs[i].gap);
            check($sformatf("vec%0d led", i),  32'(led),       32'(vecs[i].exp_led));
            check($sformatf("vec%0d hold", i), 32'(disp_hold), 32'(vecs[i].exp_hold));
            if (vecs[i].exp_en >= 0)
                check($sformatf("vec%0d en pulses", i), 32'(en_pulses), 32'(vecs[i].exp_en));
            if (vecs[i].exp_clr >= 0)
                check($sformatf("vec%0d clr pulses", i), 32'(clr_pulses), 32'(vecs[i].exp_clr));
            if (vecs[i].exp_cnt >= 0)
                check($sformatf("vec%0d cnt", i), 32'(cnt_val), 32'(vecs[i].exp_cnt));
            $display("vec %0d mask=%b led=%b hold=%b cnt=%0d", i, vecs[i].mask, led, disp_hold, cnt_val);
        end

        // Run to terminal count.
        lat = 0;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
            step();
            if (led == 4'b1000) lat = k;
        end
        check("reached DONE", 32'(lat != 0), 32'd1);
        check("DONE cnt", 32'(cnt_val), 32'(MAX_COUNT));
        en_pulses = 0;
        repeat (30) step();
        press(4'b0001, 8, 10);
        press(4'b0100, 8, 10);
        press(4'b0010, 8, 10);
        check("DONE no enables", 32'(en_pulses), 32'd0);
        check("DONE holds", 32'(led), 32'b1000);
        clr_pulses = 0;
        press(4'b1000, 8, 10);
        check("DONE clear pulses", 32'(clr_pulses), 32'd1);
        check("DONE clear led", 32'(led), 32'b0001);
        check("DONE clear cnt", 32'(cnt_val), 32'd0);
        $display("done/clear sequence: led=%b cnt=%0d", led, cnt_val);

        // Short glitches on stop while running.
        press(4'b0001, 8, 10);
        for (int g = 0; g < 6; g++) press(4'b0010, 2, 3);
        press(4'b0010, DB_CYCLES - 1, 8);
        check("glitch ignored", 32'(led), 32'b0010);
        $display("glitches on stop: led=%b", led);

        // Reset while running with lap on, start held through reset.
        press(4'b0001, 8, 10);
        check("lap before reset", 32'(disp_hold), 32'd1);
        btn_n[0] = 1'b0;
        repeat (3) step();
        async_reset_mid_cycle();
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            if (led == 4'b0010) lat = k;
        end
        check("post-reset latency", 32'(lat), 32'(DB_CYCLES + 3));
        repeat (30) step();
        check("single event led", 32'(led), 32'b0010);
        check("single event hold", 32'(disp_hold), 32'd0);
        btn_n = 4'hF;
        repeat (DB_CYCLES + 4) step();
        $display("reset in RUN: back to RUN after %0d edges", lat);

        // Randomized presses, holds and bounces against the model.
        for (int t = 0; t < 120; t++) begin
            mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) mask[3] = 1'b0;
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 16);
            press(mask, hold, gap);
            $display("txn %0d mask=%b hold=%0d gap=%0d led=%b cnt=%0d", t, mask, hold, gap, led, cnt_val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
